instruction_decode_buffer: RTL

Decode-side counterpart of the shared RV32I/RV64I instruction encoding: accepts raw 32-bit instruction words from fetch over a valid/ready handshake, splits them into fields, reconstructs the sign-extended immediate, and flags encodings outside the legal set. The block holds decoded entries in a 2-deep registered buffer between fetch and execute. It also serves as the checker that the random-instruction bench compares generated encodings against.

---
 rtl/instruction_decode_buffer_if.sv | 30 +++
 rtl/instruction_decode_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_buffer_if.sv
// instruction_decode_buffer_if: fetch-side and execute-side handshake bundle for the decode buffer
interface instruction_decode_buffer_if #(
  parameter int DATA_SIZE = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [DATA_SIZE-1:0] in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [6:0]           out_opcode;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic [DATA_SIZE-1:0] out_imm;
  logic [DATA_SIZE-1:0] out_pc;
  logic                 out_illegal;
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_pc, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/instruction_decode_buffer.sv
// instruction_decode_buffer: decodes RV32I/RV64I words and holds them in a 2-entry registered FIFO
module instruction_decode_buffer #(
  parameter bit RV64I     = 1'b1,
  parameter int DATA_SIZE = 64
) (
  input logic                        clock,
  input logic                        reset_n,
  input logic                        flush,
  instruction_decode_buffer_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_RW    = 7'h3B;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_IW    = 7'h1B;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_FENCE = 7'h0F;
  localparam logic [6:0] OP_SYS   = 7'h73;

  typedef struct packed {
    logic [31:0]          inst;
    logic [DATA_SIZE-1:0] imm;
    logic [DATA_SIZE-1:0] pc;
    logic                 illegal;
  } entry_t;

  entry_t      mem [2];
  entry_t      head;
  entry_t      fresh;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic [31:0] inst;
  logic [6:0]  op;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;
  logic        legal;
  logic        hi_zero;
  logic        hi_sra;
  logic        sys_ok;

  assign inst  = bus.in_inst;
  assign op    = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // RV64I shifts have a 6-bit shamt, so only inst[31:26] qualifies the shift kind
  assign hi_zero = RV64I ? inst[31:26] == 6'd0 : inst[31:25] == 7'd0;
  assign hi_sra  = RV64I ? inst[31:26] == 6'b010000 : inst[31:25] == 7'b0100000;
  assign sys_ok  = inst[11:7] == 5'd0 && inst[19:15] == 5'd0 &&
                   (inst[31:20] == 12'h000 || inst[31:20] == 12'h001 ||
                    inst[31:20] == 12'h102 || inst[31:20] == 12'h302);

  // immediate selection and legality by opcode
  always_comb begin
    imm32 = '0;
    legal = 1'b0;
    case (op)
      OP_R:     legal = f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_RW:    legal = RV64I && ((f3 == 3'd0 || f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) :
                                  f3 == 3'd1 ? f7 == 7'h00 : f3[2] && f7 == 7'h01);
      OP_I: begin
        imm32 = imm_i;
        legal = f3 == 3'd1 ? hi_zero : f3 == 3'd5 ? (hi_zero || hi_sra) : 1'b1;
      end
      OP_IW: begin
        imm32 = RV64I ? imm_i : '0;
        legal = RV64I && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) ||
                          (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
      end
      OP_LOAD: begin
        imm32 = imm_i;
        legal = f3 != 3'd7 && (RV64I || (f3 != 3'd3 && f3 != 3'd6));
      end
      OP_STORE: begin
        imm32 = imm_s;
        legal = !f3[2] && (RV64I || f3 != 3'd3);
      end
      OP_BR: begin
        imm32 = imm_b;
        legal = f3[2:1] != 2'b01;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = imm_u;
        legal = 1'b1;
      end
      OP_JAL: begin
        imm32 = imm_j;
        legal = 1'b1;
      end
      OP_JALR: begin
        imm32 = imm_i;
        legal = f3 == 3'd0;
      end
      OP_FENCE: legal = f3 == 3'd0;
      OP_SYS: begin
        imm32 = imm_i;
        legal = f3 == 3'd4 ? 1'b0 : f3 == 3'd0 ? sys_ok : 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign fresh = '{inst: inst, imm: DATA_SIZE'(signed'(imm32)), pc: bus.in_pc, illegal: !legal};
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;
  assign head  = mem[rd_ptr];

  // FIFO storage and pointers; flush empties the buffer but the offered word still handshakes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fresh;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign bus.in_ready    = !count[1];
  assign bus.out_valid   = count != 2'd0;
  assign bus.out_opcode  = head.inst[6:0];
  assign bus.out_rd      = head.inst[11:7];
  assign bus.out_funct3  = head.inst[14:12];
  assign bus.out_rs1     = head.inst[19:15];
  assign bus.out_rs2     = head.inst[24:20];
  assign bus.out_funct7  = head.inst[31:25];
  assign bus.out_imm     = head.imm;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.illegal;
endmodule
